kmap_result_capture: RTL

Downstream capture stage for the 3-input/4-output K-map combinational block. Accepts one (input code, output nibble) pair per handshake and stores the nibble at the slot addressed by its code. Tracks which of the 8 codes have been seen and keeps a running count of asserted output bits. Signals completion once all 8 codes are present, so the bench or a higher-level controller can read back the full truth table.

---
 rtl/kmap_result_capture.sv | 122 ++++++++++++
 1 files changed

// File: rtl/kmap_result_capture.sv
// rtl/kmap_result_capture.sv - capture stage storing K-map output nibbles by input code (optional KMAP_CAPTURE_CHECK_EN golden compare)
module kmap_result_capture #(
    parameter logic [31:0] GOLDEN = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] in_code,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] filled,
    output logic [5:0] ones_total,
    input  logic [2:0] rd_addr,
    output logic [3:0] rd_data,
    output logic       err,
    output logic [7:0] mismatch
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] mem [8];
    logic       accept;
    logic [7:0] filled_upd;

    function automatic logic [5:0] pop4(input logic [3:0] d);
        pop4 = 6'(d[0]) + 6'(d[1]) + 6'(d[2]) + 6'(d[3]);
    endfunction

    assign accept     = in_valid && in_ready && !start;
    assign filled_upd = filled | (8'd1 << in_code);
    assign rd_data    = mem[rd_addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = CAPTURE;
            end
            CAPTURE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // start wins over a same-cycle beat, so completion is only reachable without it
                if (!start && accept && filled_upd == 8'hFF) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = CAPTURE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filled     <= 8'h00;
            ones_total <= 6'd0;
            for (int i = 0; i < 8; i++) mem[i] <= 4'h0;
        end else if (start) begin
            filled     <= 8'h00;
            ones_total <= 6'd0;
            for (int i = 0; i < 8; i++) mem[i] <= 4'h0;
        end else if (accept) begin
            mem[in_code] <= in_data;
            filled       <= filled_upd;
            // old entry's bits leave the total, so overwrites never double count
            ones_total   <= ones_total - pop4(mem[in_code]) + pop4(in_data);
        end
    end

`ifdef KMAP_CAPTURE_CHECK_EN
    logic [7:0] mis_q;
    logic       err_q;
    logic [7:0] mis_next;

    always_comb begin
        mis_next          = mis_q;
        mis_next[in_code] = (in_data != GOLDEN[{in_code, 2'b00} +: 4]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_q <= 8'h00;
            err_q <= 1'b0;
        end else if (start) begin
            mis_q <= 8'h00;
            err_q <= 1'b0;
        end else if (accept) begin
            mis_q <= mis_next;
            err_q <= |mis_next;
        end
    end

    assign mismatch = mis_q;
    assign err      = err_q;
`else
    logic unused_golden;
    assign unused_golden = ^GOLDEN;
    assign mismatch      = 8'h00;
    assign err           = 1'b0;
`endif

endmodule
